cpu_ctrl_pipe: RTL and testbench

Parametrised pipeline carrier for the decoded control word, the successor to the single-cycle control bundle. It takes one decoded control word per cycle from decode and carries it through STAGES registered stages (stage 0 = EX, 1 = MEM, 2 = WB by default), each stage with a valid bit. It owns load-use hazard detection, bubble insertion, branch flush and whole-pipe freeze for multicycle memory. It also keeps a saturating stall-cycle counter.

---
 rtl/cpu_ctrl_pipe.sv | 136 +++++++++++++
 tb/tb_cpu_ctrl_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pipe.sv
// Control-word pipeline carrier: decode -> EX -> MEM -> WB.
// Owns load-use stall, branch flush, memory freeze and a stall counter.
module cpu_ctrl_pipe #(
    parameter int                 STAGES   = 3,
    parameter int                 ALU_W    = 4,
    parameter int                 IMM_W    = 3,
    parameter int                 MTR_W    = 2,
    parameter int                 RA_W     = 5,
    parameter logic [MTR_W-1:0]   MTR_LOAD = '0,
    parameter int                 CNT_W    = 32,
    parameter int                 CTRL_W   = ALU_W + IMM_W + MTR_W + 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RA_W-1:0]          in_rd,
    input  logic [RA_W-1:0]          in_rs1,
    input  logic [RA_W-1:0]          in_rs2,
    input  logic                     in_use_rs1,
    input  logic                     in_use_rs2,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     mem_wait,
    output logic [STAGES-1:0]        st_valid,
    output logic [STAGES*CTRL_W-1:0] st_ctrl,
    output logic [STAGES*RA_W-1:0]   st_rd,
    output logic                     load_use,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Field positions inside the packed control word (LSB side)
    localparam int RW_BIT  = 0;
    localparam int MTR_LSB = 6;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ADV_NORM,
        ADV_BUBBLE,
        ADV_HOLD
    } adv_e;

    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES*CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [STAGES*RA_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    adv_e adv;
    logic st0_is_load;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic stall_evt;

    // Hazard: a load sitting in EX whose destination decode wants to read
    always_comb begin
        st0_is_load = vld_q[0]
                    & ctrl_q[RW_BIT]
                    & (ctrl_q[MTR_LSB +: MTR_W] == MTR_LOAD)
                    & (rd_q[RA_W-1:0] != '0);
        rs1_hit = in_use_rs1 & (in_rs1 == rd_q[RA_W-1:0]);
        rs2_hit = in_use_rs2 & (in_rs2 == rd_q[RA_W-1:0]);
        hazard  = st0_is_load & in_valid & (rs1_hit | rs2_hit);
    end

    assign load_use = hazard;
    assign in_ready = ~mem_wait & (~hazard | flush);

    // Pick this cycle's advance mode: freeze beats flush beats stall
    always_comb begin
        adv = ADV_NORM;
        priority case (1'b1)
            mem_wait: adv = ADV_HOLD;
            flush:    adv = ADV_BUBBLE;
            hazard:   adv = ADV_BUBBLE;
            default:  adv = ADV_NORM;
        endcase
    end

    // A freeze cycle and a stall cycle overlap into one count
    assign stall_evt = mem_wait | (hazard & ~flush);

    // Next-state for the stage registers
    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (adv != ADV_HOLD) begin
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i]                 = vld_q[i-1];
                ctrl_d[i*CTRL_W +: CTRL_W] = ctrl_q[(i-1)*CTRL_W +: CTRL_W];
                rd_d[i*RA_W +: RA_W]       = rd_q[(i-1)*RA_W +: RA_W];
            end
            if (adv == ADV_NORM && in_valid) begin
                vld_d[0]              = 1'b1;
                ctrl_d[CTRL_W-1:0]    = in_ctrl;
                rd_d[RA_W-1:0]        = in_rd;
            end else begin
                vld_d[0]              = 1'b0;
                ctrl_d[CTRL_W-1:0]    = '0;
                rd_d[RA_W-1:0]        = '0;
            end
        end
    end

    // Saturating stall counter next-state
    always_comb begin
        cnt_d = cnt_q;
        if (stall_evt && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Stage and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign st_valid  = vld_q;
    assign st_ctrl   = ctrl_q;
    assign st_rd     = rd_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_pipe.sv
// Directed bench for cpu_ctrl_pipe: stream, load-use, flush,
// freeze, reset mid-freeze and counter saturation.
module tb_cpu_ctrl_pipe;

    localparam int CW = 15;
    localparam logic [CW-1:0] ADD = 15'h1041;
    localparam logic [CW-1:0] LDW = 15'h0121;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic          in_use_rs1, in_use_rs2;
    logic          flush, mem_wait;

    logic          in_ready, load_use;
    logic [2:0]    st_valid;
    logic [3*CW-1:0] st_ctrl;
    logic [14:0]   st_rd;
    logic [31:0]   stall_cnt;

    logic          s_ready, s_lu;
    logic [2:0]    s_valid;
    logic [3*CW-1:0] s_ctrl;
    logic [14:0]   s_rd;
    logic [3:0]    s_cnt;

    int total = 0;
    int bad   = 0;

    cpu_ctrl_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_ready(in_ready), .flush(flush), .mem_wait(mem_wait),
        .st_valid(st_valid), .st_ctrl(st_ctrl), .st_rd(st_rd),
        .load_use(load_use), .stall_cnt(stall_cnt)
    );

    cpu_ctrl_pipe #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_ready(s_ready), .flush(flush), .mem_wait(mem_wait),
        .st_valid(s_valid), .st_ctrl(s_ctrl), .st_rd(s_rd),
        .load_use(s_lu), .stall_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [4:0] rd, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2,
                         input logic u2);
        in_valid   = v;
        in_ctrl    = c;
        in_rd      = rd;
        in_rs1     = r1;
        in_use_rs1 = u1;
        in_rs2     = r2;
        in_use_rs2 = u2;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_wait = 1'b0;
        drive(0, '0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_valid", st_valid, 0);
        chk("rst_ctrl", st_ctrl, 0);
        chk("rst_rd", st_rd, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_sat_valid", s_valid, 0);
        chk("rst_sat_rd", s_rd, 0);
        chk("rst_sat_ctrl", s_ctrl, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sat_ready", s_ready, 1);
        rst = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            drive(1, ADD, 5'(k), 0, 0, 0, 0);
            #1;
            chk("str_ready", in_ready, 1);
            step();
            chk("str_rd0", st_rd[4:0], 64'(k));
            if (k == 1) chk("str_ctrl0", st_ctrl[CW-1:0], ADD);
            if (k == 2) chk("str_rd1", st_rd[9:5], 1);
            if (k == 3) begin
                chk("str_rd_all", st_rd, {5'd1, 5'd2, 5'd3});
                chk("str_valid", st_valid, 3'b111);
            end
        end

        drive(1, LDW, 5, 0, 0, 0, 0);
        step();
        drive(1, ADD, 6, 5, 1, 0, 0);
        #1;
        chk("lu_flag", load_use, 1);
        chk("lu_ready", in_ready, 0);
        chk("sat_lu_flag", s_lu, 1);
        step();
        chk("lu_bubble", st_valid[0], 0);
        chk("lu_ld_st1", st_rd[9:5], 5);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_ready2", in_ready, 1);
        step();
        chk("lu_dep_rd", st_rd[4:0], 6);
        chk("lu_dep_v", st_valid[0], 1);
        chk("lu_cnt2", stall_cnt, 1);

        drive(1, LDW, 0, 0, 0, 0, 0);
        step();
        drive(1, ADD, 7, 0, 1, 0, 1);
        #1;
        chk("rd0_flag", load_use, 0);
        chk("rd0_ready", in_ready, 1);
        step();
        chk("rd0_rd", st_rd[4:0], 7);
        chk("rd0_cnt", stall_cnt, 1);

        drive(1, LDW, 9, 0, 0, 0, 0);
        step();
        drive(1, ADD, 10, 3, 1, 9, 1);
        #1;
        chk("rs2_flag", load_use, 1);
        flush = 1'b1;
        #1;
        chk("fl_ready", in_ready, 1);
        step();
        flush = 1'b0;
        chk("fl_bubble", st_valid[0], 0);
        chk("fl_rd0", st_rd[4:0], 0);
        chk("fl_st1", st_rd[9:5], 9);
        chk("fl_cnt", stall_cnt, 1);

        for (int k = 11; k <= 13; k++) begin
            drive(1, ADD, 5'(k), 0, 0, 0, 0);
            step();
        end
        chk("fz_fill", st_rd, {5'd11, 5'd12, 5'd13});
        mem_wait = 1'b1;
        flush = 1'b1;
        drive(1, ADD, 14, 0, 0, 0, 0);
        #1;
        chk("fz_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fz_rd", st_rd, {5'd11, 5'd12, 5'd13});
            chk("fz_valid", st_valid, 3'b111);
        end
        chk("fz_cnt", stall_cnt, 4);
        mem_wait = 1'b0;
        #1;
        chk("fz_ready2", in_ready, 1);
        step();
        flush = 1'b0;
        chk("fz_fl_rd", st_rd, {5'd12, 5'd13, 5'd0});
        chk("fz_fl_v", st_valid, 3'b110);
        chk("fz_fl_cnt", stall_cnt, 4);

        for (int k = 15; k <= 17; k++) begin
            drive(1, ADD, 5'(k), 0, 0, 0, 0);
            step();
        end
        mem_wait = 1'b1;
        step();
        chk("mf_cnt", stall_cnt, 5);
        chk("mf_valid", st_valid, 3'b111);
        rst = 1'b1;
        step();
        chk("mf_rst_v", st_valid, 0);
        chk("mf_rst_rd", st_rd, 0);
        chk("mf_rst_ctrl", st_ctrl, 0);
        chk("mf_rst_cnt", stall_cnt, 0);
        chk("mf_rst_scnt", s_cnt, 0);
        rst = 1'b0;

        drive(0, '0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) chk("sat_14", s_cnt, 14);
            if (k == 15) chk("sat_15", s_cnt, 15);
        end
        chk("sat_hold", s_cnt, 15);
        chk("sat_wide", stall_cnt, 20);

        mem_wait = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, LDW, 5, 0, 0, 0, 0);
        step();
        drive(1, ADD, 6, 0, 0, 5, 1);
        mem_wait = 1'b1;
        step();
        chk("once_cnt", stall_cnt, 1);
        chk("once_hold", st_rd[4:0], 5);
        mem_wait = 1'b0;
        step();
        chk("once_cnt2", stall_cnt, 2);
        chk("once_bub", st_valid[0], 0);
        step();
        chk("once_dep", st_rd[4:0], 6);
        chk("once_cnt3", stall_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
